mem_bridge: RTL
===============

Name: mem_bridge

Overview:
- Sits directly downstream of the Riscv151 core's memory ports.
- Turns the core's per-cycle icache/dcache accesses into serialized transactions on one valid/ready main-memory port.
- Returns read data on icache_dout/dcache_dout and drives the core's stall input while any access is outstanding.
- Data access is always served before instruction fetch.

Parameters:
- ADDR_W, 32, width of core and memory addresses (byte addresses).
- TIMEOUT, 255, maximum cycles spent waiting for a memory response before the access is abandoned.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- icache_addr  input  ADDR_W  fetch address from core.
- icache_re  input  1  fetch request.
- icache_dout  output  32  fetch data to core.
- dcache_addr  input  ADDR_W  load/store address from core.
- dcache_re  input  1  load request.
- dcache_we  input  4  store byte mask.
- dcache_din  input  32  store data.
- dcache_dout  output  32  load data to core.
- stall  output  1  freezes the core pipeline.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_rw  output  1  1 = write, 0 = read.
- mem_req_addr  output  ADDR_W  word-aligned address (low 2 bits forced 0).
- mem_req_data  output  32  write data.
- mem_req_mask  output  4  write byte mask (0 on reads).
- mem_resp_valid  input  1  read response valid.
- mem_resp_data  input  32  read response data.
- timeout_err  output  1  sticky flag: a memory response timed out.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - stall, mem_req_valid, mem_req_rw, mem_req_mask, timeout_err, icache_dout, dcache_dout, mem_req_addr, mem_req_data, and all capture registers go to 0.
  - Reset mid-transaction abandons the transaction. A later mem_resp_valid seen in IDLE is ignored.
- States: IDLE, D_REQ, D_RESP, I_REQ, I_RESP.
- stall is registered and equals 1 exactly when state ≠ IDLE.
- Capture in IDLE:
  - Condition: d = dcache_re | (|dcache_we); i = icache_re. Nothing is captured if both are 0.
  - Latched at the edge: addresses, dcache_din, dcache_we, and flags d_pend = d, i_pend = i, d_is_wr = |dcache_we.
  - dcache_we takes priority over dcache_re when both are set.
  - Next state: D_REQ if d, else I_REQ.
- D_REQ:
  - Drive mem_req_valid = 1, rw = d_is_wr, addr = daddr & ~3, data, mask.
  - mem_req_valid stays high and all fields stay stable until mem_req_ready.
  - On handshake, a write goes to I_REQ if i_pend, else IDLE. Writes expect no response.
  - On handshake, a read goes to D_RESP.
- D_RESP:
  - On mem_resp_valid, capture mem_resp_data into dcache_dout.
  - Next state: I_REQ if i_pend, else IDLE.
- I_REQ / I_RESP: same as the read path, using the fetch address, with data captured into icache_dout.
- Timeout:
  - The counter clears on entry to any *_RESP state and increments each cycle without a response.
  - When it reaches TIMEOUT: the corresponding dout gets 32'h0000_0013 (NOP) for fetch or 32'h0 for load, timeout_err is set, and the FSM proceeds as if the response had arrived.
  - timeout_err clears only on reset.
- Output holding: icache_dout and dcache_dout hold their last captured value until the next capture of the same kind. They are valid in the first IDLE cycle after the transaction, which is the cycle stall is low and the core advances.
- Minimum latency (ready = 1, response one cycle after handshake):
  - Fetch only: stall high 2 cycles.
  - Load plus fetch: stall high 4 cycles.
  - Store plus fetch: stall high 3 cycles.
- IDLE after a transaction may capture a new request in the same cycle stall is low. Back-to-back transactions have exactly one stall-low cycle between them.
- mem_resp_valid outside a *_RESP state is ignored.

Test Plan:
- Fetch only: icache_re = 1, addr 0x1004; memory ready = 1, response 0xDEADBEEF one cycle later -> stall high for 2 cycles, req addr 0x1004 with rw = 0, icache_dout = 0xDEADBEEF on the stall-low cycle.
- Load plus fetch: dcache_re, addr 0x2002, and fetch 0x1008 together -> first request addr 0x2000 (data), second 0x1008; dcache_dout and icache_dout hold their respective responses; stall high 4 cycles.
- Store with backpressure: dcache_we = 4'b0011, din 0x12345678, addr 0x3000; mem_req_ready low for 3 cycles -> valid, addr, data and mask stable throughout; no response awaited; fetch issued next.
- Timeout: fetch with no mem_resp_valid for TIMEOUT cycles -> icache_dout = 0x00000013, timeout_err = 1 and stays 1; the next fetch completes normally.
- Reset mid-operation: assert reset while in D_RESP, then deassert -> stall = 0 and state IDLE immediately; a stale mem_resp_valid afterward does not change dcache_dout (stays 0).
- Idle: no re/we for 10 cycles -> stall = 0, mem_req_valid = 0, outputs unchanged.

Source files
------------

// File: rtl/mem_bridge.sv
// Serializes the core's dcache/icache accesses onto one valid/ready memory port, data first.
// Fetch-only stalls 2 cycles; request fields hold under backpressure; missing responses abandon after TIMEOUT.
module mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_re,
  output logic [31:0]       icache_dout,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              timeout_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] D_REQ  = 3'd1;
  localparam logic [2:0] D_RESP = 3'd2;
  localparam logic [2:0] I_REQ  = 3'd3;
  localparam logic [2:0] I_RESP = 3'd4;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [31:0]      NOP    = 32'h0000_0013;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:2] iaddr_q, daddr_q;
  logic [31:0]       din_q;
  logic [3:0]        we_q;
  logic              d_pend_q, i_pend_q, d_is_wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              d_req, expired, resp_done;

  assign d_req     = dcache_re | (|dcache_we);
  assign expired   = (cnt_q == TO_CNT);
  assign resp_done = mem_resp_valid | expired;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)          state_nxt = D_REQ;
        else if (icache_re) state_nxt = I_REQ;
      end
      D_REQ: begin
        // Stores complete at the handshake; only loads wait for a response.
        if (mem_req_ready) begin
          if (!d_is_wr_q)    state_nxt = D_RESP;
          else if (i_pend_q) state_nxt = I_REQ;
          else               state_nxt = IDLE;
        end
      end
      D_RESP: if (resp_done) state_nxt = i_pend_q ? I_REQ : IDLE;
      I_REQ:  if (mem_req_ready) state_nxt = I_RESP;
      I_RESP: if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    if (state == D_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = d_is_wr_q;
      mem_req_addr  = {daddr_q, 2'b00};
      mem_req_data  = din_q;
      mem_req_mask  = d_is_wr_q ? we_q : 4'h0;
    end else if (state == I_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {iaddr_q, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      stall       <= 1'b0;
      iaddr_q     <= '0;
      daddr_q     <= '0;
      din_q       <= '0;
      we_q        <= '0;
      d_pend_q    <= 1'b0;
      i_pend_q    <= 1'b0;
      d_is_wr_q   <= 1'b0;
      cnt_q       <= '0;
      icache_dout <= '0;
      dcache_dout <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      stall <= (state_nxt != IDLE);

      if (state == IDLE && (d_req || icache_re)) begin
        iaddr_q   <= icache_addr[ADDR_W-1:2];
        daddr_q   <= dcache_addr[ADDR_W-1:2];
        din_q     <= dcache_din;
        we_q      <= dcache_we;
        d_pend_q  <= d_req;
        i_pend_q  <= icache_re;
        d_is_wr_q <= |dcache_we;
      end

      // Every *_RESP state is entered from a *_REQ state, so the counter starts at 0.
      if (state == D_RESP || state == I_RESP) cnt_q <= cnt_q + 1'b1;
      else                                    cnt_q <= '0;

      if (state == D_RESP) begin
        if (mem_resp_valid) dcache_dout <= mem_resp_data;
        else if (expired) begin
          dcache_dout <= 32'h0;
          timeout_err <= 1'b1;
        end
      end

      if (state == I_RESP) begin
        if (mem_resp_valid) icache_dout <= mem_resp_data;
        else if (expired) begin
          icache_dout <= NOP;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
